// File: rtl/bus_arbiter.sv
// Two-master arbiter and access sequencer for the Bridge data bus.
// Each granted access holds the bus for LAT cycles and returns a registered ack with read data.
`timescale 1ns/1ps

module bus_arbiter #(
    parameter int LAT        = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic [31:0] Bus_addr,
    output logic        Bus_wen,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata,

    output logic        busy,
    output logic        gnt_id,
    output logic        cpu_stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last, last_nxt;
    logic        owner, owner_nxt;
    logic [31:0] acc_addr, acc_addr_nxt;
    logic [31:0] acc_wdata, acc_wdata_nxt;
    logic        acc_wen, acc_wen_nxt;

    logic        elig0, elig1;
    logic        grant, winner;
    logic        done;

    // A master whose ack is high this cycle is not eligible, so a held req cannot re-grant.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;
    assign grant = elig0 | elig1;
    assign done  = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        if (elig0 && elig1) begin
            winner = FIXED_PRIO ? 1'b0 : ~last;
        end else begin
            winner = elig1;
        end
    end

    // NOTE: every signal driven here is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last;
        owner_nxt     = owner;
        acc_addr_nxt  = acc_addr;
        acc_wdata_nxt = acc_wdata;
        acc_wen_nxt   = acc_wen;

        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt     = BUSY;
                    cnt_nxt       = CNT_LOAD;
                    last_nxt      = winner;
                    owner_nxt     = winner;
                    acc_addr_nxt  = winner ? m1_addr  : m0_addr;
                    acc_wdata_nxt = winner ? m1_wdata : m0_wdata;
                    acc_wen_nxt   = winner ? m1_wen   : m0_wen;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;
            owner     <= 1'b0;
            acc_addr  <= 32'd0;
            acc_wdata <= 32'd0;
            acc_wen   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            acc_addr  <= acc_addr_nxt;
            acc_wdata <= acc_wdata_nxt;
            acc_wen   <= acc_wen_nxt;
        end
    end

    // Completion: ack the owner one cycle after the final BUSY cycle; only reads update rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
        end else begin
            m0_ack <= done & ~owner;
            m1_ack <= done &  owner;
            if (done && !acc_wen) begin
                if (owner) begin
                    m1_rdata <= Bus_rdata;
                end else begin
                    m0_rdata <= Bus_rdata;
                end
            end
        end
    end

    assign busy      = (state == BUSY);
    assign gnt_id    = owner;
    assign Bus_addr  = busy ? acc_addr  : 32'd0;
    assign Bus_wdata = busy ? acc_wdata : 32'd0;
    assign Bus_wen   = done & acc_wen;
    assign cpu_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: four instances cover LAT=1/3/4 and both arbitration modes,
// each with its own Bridge memory model.
`timescale 1ns/1ps

module tb_bus_arbiter;

    localparam int NI = 4;

    typedef struct {
        logic        mst;
        logic        rd;
        logic [31:0] data;
        int          cyc;
    } sb_entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [NI];
    logic        m0_req    [NI];
    logic [31:0] m0_addr   [NI];
    logic        m0_wen    [NI];
    logic [31:0] m0_wdata  [NI];
    logic [31:0] m0_rdata  [NI];
    logic        m0_ack    [NI];
    logic        m1_req    [NI];
    logic [31:0] m1_addr   [NI];
    logic        m1_wen    [NI];
    logic [31:0] m1_wdata  [NI];
    logic [31:0] m1_rdata  [NI];
    logic        m1_ack    [NI];
    logic [31:0] bus_addr  [NI];
    logic        bus_wen   [NI];
    logic [31:0] bus_wdata [NI];
    logic        busy      [NI];
    logic        gnt_id    [NI];
    logic        cpu_stall [NI];
    logic        pl_we     [NI];
    logic [31:0] pl_addr   [NI];
    logic [31:0] pl_data   [NI];

    // Instance 0: LAT=1 round-robin, 1: LAT=3 round-robin, 2: LAT=1 fixed priority, 3: LAT=4 round-robin.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] mem [64];
        logic [31:0] bus_rdata;

        assign bus_rdata = mem[bus_addr[g][7:2]];

        always @(posedge clk) begin
            if (bus_wen[g]) begin
                mem[bus_addr[g][7:2]] <= bus_wdata[g];
            end else if (pl_we[g]) begin
                mem[pl_addr[g][7:2]] <= pl_data[g];
            end
        end

        bus_arbiter #(
            .LAT       (g == 1 ? 3 : (g == 3 ? 4 : 1)),
            .FIXED_PRIO(g == 2)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .m0_req   (m0_req[g]),
            .m0_addr  (m0_addr[g]),
            .m0_wen   (m0_wen[g]),
            .m0_wdata (m0_wdata[g]),
            .m0_rdata (m0_rdata[g]),
            .m0_ack   (m0_ack[g]),
            .m1_req   (m1_req[g]),
            .m1_addr  (m1_addr[g]),
            .m1_wen   (m1_wen[g]),
            .m1_wdata (m1_wdata[g]),
            .m1_rdata (m1_rdata[g]),
            .m1_ack   (m1_ack[g]),
            .Bus_addr (bus_addr[g]),
            .Bus_wen  (bus_wen[g]),
            .Bus_wdata(bus_wdata[g]),
            .Bus_rdata(bus_rdata),
            .busy     (busy[g]),
            .gnt_id   (gnt_id[g]),
            .cpu_stall(cpu_stall[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    sb_entry_t   sb [$];
    logic [31:0] exp_rd [NI][2];
    bit          acked [2];
    int          rem [2];
    int          stall_cnt;
    int          wen_cnt;
    int          wen_cyc;
    logic [31:0] wen_addr;
    logic [31:0] wen_data;

    task automatic expect_ack(input logic mst, input logic rd, input logic [31:0] data, input int at);
        sb_entry_t e;
        e.mst  = mst;
        e.rd   = rd;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic issue(input int i, input int m, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata);
        if (m == 0) begin
            m0_addr[i] = addr; m0_wen[i] = wen; m0_wdata[i] = wdata; m0_req[i] = 1'b1;
        end else begin
            m1_addr[i] = addr; m1_wen[i] = wen; m1_wdata[i] = wdata; m1_req[i] = 1'b1;
        end
    endtask

    task automatic drop_req(input int i, input int m);
        if (m == 0) m0_req[i] = 1'b0;
        else        m1_req[i] = 1'b0;
    endtask

    // Samples one cycle of instance i at the falling edge and retires scoreboard entries on acks.
    task automatic mon(input int i);
        sb_entry_t   e;
        logic [31:0] got;
        @(negedge clk);
        acked[0] = m0_ack[i];
        acked[1] = m1_ack[i];
        if (cpu_stall[i]) stall_cnt++;
        if (bus_wen[i]) begin
            wen_cnt++;
            wen_cyc  = cyc;
            wen_addr = bus_addr[i];
            wen_data = bus_wdata[i];
        end
        if (busy[i] && sb.size() != 0) begin
            n_vec++;
            if (gnt_id[i] !== sb[0].mst) begin
                n_err++;
                $display("FAIL gnt_id inst%0d cyc %0d: got %0d want %0d", i, cyc, gnt_id[i], sb[0].mst);
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (acked[m]) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack inst%0d m%0d cyc %0d: got ack want none", i, m, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.mst !== 1'(m) || e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL ack_order inst%0d: got m%0d at cyc %0d want m%0d at cyc %0d",
                                 i, m, cyc, e.mst, e.cyc);
                    end
                    if (e.rd) exp_rd[i][m] = e.data;
                    got = (m == 0) ? m0_rdata[i] : m1_rdata[i];
                    n_vec++;
                    if (got !== exp_rd[i][m]) begin
                        n_err++;
                        $display("FAIL rdata inst%0d m%0d cyc %0d: got %h want %h", i, m, cyc, got, exp_rd[i][m]);
                    end
                end
            end
        end
    endtask

    task automatic cyc_step(input int i);
        mon(i);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) cyc_step(i);
    endtask

    // Runs instance i until the scoreboard drains; each master drops req after its last expected ack.
    task automatic run(input int i, input int budget, input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            cyc_step(i);
            k++;
            for (int m = 0; m < 2; m++) begin
                if (acked[m]) begin
                    rem[m]--;
                    if (rem[m] <= 0) drop_req(i, m);
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout inst%0d: got %0d accesses outstanding want 0", name, i, sb.size());
            sb.delete();
        end
    endtask

    task automatic preload(input int i, input logic [31:0] addr, input logic [31:0] data);
        pl_we[i] = 1'b1; pl_addr[i] = addr; pl_data[i] = data;
        @(posedge clk);
        #1;
        pl_we[i] = 1'b0;
    endtask

    task automatic pulse_reset(input int i);
        rst_n[i] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[i] = 1'b1;
        exp_rd[i][0] = 32'd0;
        exp_rd[i][1] = 32'd0;
    endtask

    task automatic test_reset();
        preload(0, 32'h10, 32'hDEAD_BEEF);
        preload(0, 32'h14, 32'h1111_2222);
        preload(3, 32'h30, 32'h0000_0000);
        preload(3, 32'h34, 32'h3434_3434);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({bus_addr[i], bus_wdata[i], bus_wen[i], busy[i], gnt_id[i], m0_ack[i], m1_ack[i]} !== '0) begin
                n_err++;
                $display("FAIL reset_ctrl inst%0d: got addr=%h wdata=%h wen=%b busy=%b gnt=%b ack=%b%b want all 0",
                         i, bus_addr[i], bus_wdata[i], bus_wen[i], busy[i], gnt_id[i], m0_ack[i], m1_ack[i]);
            end
            n_vec++;
            if ({m0_rdata[i], m1_rdata[i], cpu_stall[i]} !== '0) begin
                n_err++;
                $display("FAIL reset_data inst%0d: got rdata0=%h rdata1=%h stall=%b want all 0",
                         i, m0_rdata[i], m1_rdata[i], cpu_stall[i]);
            end
        end
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        idle(0, 2);
    endtask

    task automatic test_single_read();
        int c0;
        stall_cnt = 0;
        c0 = cyc;
        issue(0, 0, 32'h10, 1'b0, 32'd0);
        expect_ack(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 2);
        rem[0] = 1;
        run(0, 10, "single_read");
        idle(0, 2);
        n_vec++;
        if (stall_cnt != 2) begin
            n_err++;
            $display("FAIL stall_cycles: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_write_read();
        int c0;
        wen_cnt = 0;
        c0 = cyc;
        issue(1, 1, 32'h20, 1'b1, 32'hA5A5_0001);
        expect_ack(1'b1, 1'b0, 32'd0, c0 + 4);
        rem[1] = 1;
        run(1, 12, "write");
        n_vec++;
        if (wen_cnt != 1 || wen_cyc != c0 + 3) begin
            n_err++;
            $display("FAIL write_strobe: got %0d strobes last at cyc %0d want 1 at cyc %0d", wen_cnt, wen_cyc, c0 + 3);
        end
        n_vec++;
        if (wen_addr !== 32'h20 || wen_data !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL write_beat: got addr=%h data=%h want addr=00000020 data=a5a50001", wen_addr, wen_data);
        end
        c0 = cyc;
        issue(1, 1, 32'h20, 1'b0, 32'd0);
        expect_ack(1'b1, 1'b1, 32'hA5A5_0001, c0 + 4);
        rem[1] = 1;
        run(1, 12, "read_back");
        idle(1, 3);
        n_vec++;
        if (wen_cnt != 1) begin
            n_err++;
            $display("FAIL read_strobe: got %0d strobes want 1", wen_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        pulse_reset(0);
        c0 = cyc;
        issue(0, 0, 32'h10, 1'b0, 32'd0);
        issue(0, 1, 32'h14, 1'b0, 32'd0);
        expect_ack(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 2);
        expect_ack(1'b1, 1'b1, 32'h1111_2222, c0 + 4);
        expect_ack(1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 6);
        expect_ack(1'b1, 1'b1, 32'h1111_2222, c0 + 8);
        rem[0] = 2;
        rem[1] = 2;
        run(0, 20, "round_robin");
        idle(0, 3);
    endtask

    task automatic test_held_req();
        int c0;
        c0 = cyc;
        issue(0, 0, 32'h14, 1'b0, 32'd0);
        expect_ack(1'b0, 1'b1, 32'h1111_2222, c0 + 2);
        expect_ack(1'b0, 1'b1, 32'h1111_2222, c0 + 5);
        rem[0] = 2;
        run(0, 12, "held_req");
        idle(0, 3);
    endtask

    task automatic test_fixed_prio();
        int c0;
        for (int r = 0; r < 3; r++) begin
            c0 = cyc;
            issue(2, 0, 32'h40, 1'b1, 32'(r));
            expect_ack(1'b0, 1'b0, 32'd0, c0 + 2);
            rem[0] = 1;
            run(2, 8, "fixed_solo");
            c0 = cyc;
            issue(2, 0, 32'h50, 1'b1, 32'h5000 + 32'(r));
            issue(2, 1, 32'h60, 1'b1, 32'h6000 + 32'(r));
            expect_ack(1'b0, 1'b0, 32'd0, c0 + 2);
            expect_ack(1'b1, 1'b0, 32'd0, c0 + 4);
            rem[0] = 1;
            rem[1] = 1;
            run(2, 12, "fixed_tie");
        end
        idle(2, 3);
    endtask

    task automatic test_reset_mid();
        int c0;
        wen_cnt = 0;
        issue(3, 0, 32'h30, 1'b1, 32'hBAD0_BAD0);
        cyc_step(3);
        cyc_step(3);
        rst_n[3]  = 1'b0;
        m0_req[3] = 1'b0;
        idle(3, 3);
        n_vec++;
        if ({bus_addr[3], bus_wdata[3], bus_wen[3], busy[3], gnt_id[3], m0_ack[3], m1_ack[3],
             m0_rdata[3], m1_rdata[3], cpu_stall[3]} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got addr=%h wen=%b busy=%b gnt=%b ack=%b%b want all 0",
                     bus_addr[3], bus_wen[3], busy[3], gnt_id[3], m0_ack[3], m1_ack[3]);
        end
        rst_n[3] = 1'b1;
        exp_rd[3][0] = 32'd0;
        exp_rd[3][1] = 32'd0;
        idle(3, 3);
        n_vec++;
        if (wen_cnt != 0) begin
            n_err++;
            $display("FAIL mid_reset_strobe: got %0d strobes want 0", wen_cnt);
        end
        c0 = cyc;
        issue(3, 0, 32'h30, 1'b0, 32'd0);
        issue(3, 1, 32'h34, 1'b0, 32'd0);
        expect_ack(1'b0, 1'b1, 32'h0000_0000, c0 + 5);
        expect_ack(1'b1, 1'b1, 32'h3434_3434, c0 + 10);
        rem[0] = 1;
        rem[1] = 1;
        run(3, 20, "post_reset_tie");
        idle(3, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i]  = 1'b0;
            m0_req[i] = 1'b0; m0_addr[i] = '0; m0_wen[i] = 1'b0; m0_wdata[i] = '0;
            m1_req[i] = 1'b0; m1_addr[i] = '0; m1_wen[i] = 1'b0; m1_wdata[i] = '0;
            pl_we[i]  = 1'b0; pl_addr[i] = '0; pl_data[i] = '0;
            exp_rd[i][0] = '0;
            exp_rd[i][1] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_held_req();
        test_fixed_prio();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
